fir_axil_regs: RTL and testbench

AXI4-Lite slave register bank, the responder to the FIR subsystem's AXI4-Lite master. It holds four 32-bit software-visible registers used to configure the FIR filter core, and drives those register values plus per-register write pulses into the core. Write and read channels operate independently, with full VALID/READY back-pressure on every channel.

---
 rtl/fir_axil_regs.sv | 170 +++++++++++++++++
 tb/tb_fir_axil_regs.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_axil_regs.sv
// AXI4-Lite slave register bank holding the FIR core configuration registers.
// Write and read channels run independently with full VALID/READY back-pressure.
module fir_axil_regs #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_NUM_REGS         = 4
) (
  input  logic                                      ACLK,
  input  logic                                      ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]             S_AXI_AWADDR,
  input  logic [2:0]                                S_AXI_AWPROT,
  input  logic                                      S_AXI_AWVALID,
  output logic                                      S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]             S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]           S_AXI_WSTRB,
  input  logic                                      S_AXI_WVALID,
  output logic                                      S_AXI_WREADY,
  output logic [1:0]                                S_AXI_BRESP,
  output logic                                      S_AXI_BVALID,
  input  logic                                      S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]             S_AXI_ARADDR,
  input  logic [2:0]                                S_AXI_ARPROT,
  input  logic                                      S_AXI_ARVALID,
  output logic                                      S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]             S_AXI_RDATA,
  output logic [1:0]                                S_AXI_RRESP,
  output logic                                      S_AXI_RVALID,
  input  logic                                      S_AXI_RREADY,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]  regs_o,
  output logic [C_NUM_REGS-1:0]                     reg_wr_pulse
);

  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned NB = DW / 8;
  localparam int unsigned NR = C_NUM_REGS;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // Write-side state
  logic                   r_aw_latched;
  logic                   r_w_latched;
  logic [AW-1:0]          r_awaddr;
  logic [DW-1:0]          r_wdata;
  logic [NB-1:0]          r_wstrb;
  logic                   r_bvalid;
  logic [1:0]             r_bresp;
  logic [NR-1:0]          r_wr_pulse;
  logic [NR-1:0][DW-1:0]  r_regs;

  // Read-side state
  logic                   r_rvalid;
  logic [1:0]             r_rresp;
  logic [DW-1:0]          r_rdata;

  logic                   w_awready;
  logic                   w_wready;
  logic                   w_arready;
  logic                   w_aw_hs;
  logic                   w_w_hs;
  logic                   w_ar_hs;
  logic                   w_commit;
  logic [AW-1:0]          w_wr_addr;
  logic [DW-1:0]          w_wr_data;
  logic [NB-1:0]          w_wr_strb;
  logic [1:0]             w_wr_idx;
  logic                   w_wr_oor;
  logic [1:0]             w_rd_idx;
  logic                   w_rd_oor;
  logic                   w_unused;

  // Ready/handshake decode; readies fall with reset or an outstanding response
  always_comb begin
    w_awready = !r_aw_latched && !r_bvalid && !ARESET;
    w_wready  = !r_w_latched  && !r_bvalid && !ARESET;
    w_arready = !r_rvalid && !ARESET;
    w_aw_hs   = S_AXI_AWVALID && w_awready;
    w_w_hs    = S_AXI_WVALID  && w_wready;
    w_ar_hs   = S_AXI_ARVALID && w_arready;
    // Commit once both halves are either latched or arriving this cycle
    w_commit  = (r_aw_latched || w_aw_hs) && (r_w_latched || w_w_hs) && !r_bvalid;
    w_wr_addr = r_aw_latched ? r_awaddr : S_AXI_AWADDR;
    w_wr_data = r_w_latched  ? r_wdata  : S_AXI_WDATA;
    w_wr_strb = r_w_latched  ? r_wstrb  : S_AXI_WSTRB;
    w_wr_idx  = w_wr_addr[3:2];
    w_wr_oor  = |(w_wr_addr >> 4);
    w_rd_idx  = S_AXI_ARADDR[3:2];
    w_rd_oor  = |(S_AXI_ARADDR >> 4);
  end

  // Protection bits and byte-lane address bits carry no meaning here
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Hold whichever of AW / W completes first until its partner arrives
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_aw_latched <= 1'b0;
      r_w_latched  <= 1'b0;
      r_awaddr     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
    end else if (w_commit) begin
      r_aw_latched <= 1'b0;
      r_w_latched  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_latched <= 1'b1;
        r_awaddr     <= S_AXI_AWADDR;
      end
      if (w_w_hs) begin
        r_w_latched <= 1'b1;
        r_wdata     <= S_AXI_WDATA;
        r_wstrb     <= S_AXI_WSTRB;
      end
    end
  end

  // Register file update, write pulse and write response
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_regs     <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit) begin
        r_bvalid <= 1'b1;
        if (w_wr_oor) begin
          r_bresp <= RESP_SLVERR;
        end else begin
          r_bresp    <= RESP_OKAY;
          r_wr_pulse <= NR'(1) << w_wr_idx;
          for (int k = 0; k < int'(NB); k++) begin
            if (w_wr_strb[k]) r_regs[w_wr_idx][8*k +: 8] <= w_wr_data[8*k +: 8];
          end
        end
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Read channel; data sampled before any same-edge write lands
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_rd_oor ? RESP_SLVERR : RESP_OKAY;
      r_rdata  <= w_rd_oor ? '0 : r_regs[w_rd_idx];
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;
  assign regs_o        = r_regs;
  assign reg_wr_pulse  = r_wr_pulse;

endmodule

// File: tb/tb_fir_axil_regs.sv
// Directed bench for the FIR AXI4-Lite register bank (8-bit address variant).
module tb_fir_axil_regs;

  localparam int unsigned AW = 8;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [AW-1:0] S_AXI_AWADDR = '0;
  logic [2:0]    S_AXI_AWPROT = '0;
  logic          S_AXI_AWVALID = 1'b0;
  logic          S_AXI_AWREADY;
  logic [31:0]   S_AXI_WDATA = '0;
  logic [3:0]    S_AXI_WSTRB = '0;
  logic          S_AXI_WVALID = 1'b0;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY = 1'b0;
  logic [AW-1:0] S_AXI_ARADDR = '0;
  logic [2:0]    S_AXI_ARPROT = '0;
  logic          S_AXI_ARVALID = 1'b0;
  logic          S_AXI_ARREADY;
  logic [31:0]   S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY = 1'b0;
  logic [127:0]  regs_o;
  logic [3:0]    reg_wr_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  fir_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(AW),
    .C_NUM_REGS(4)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .regs_o(regs_o), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    strb;
    logic [31:0]   exp_rd;
    logic [1:0]    exp_bresp;
    logic [1:0]    exp_rresp;
    logic [3:0]    exp_pulse;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [3:0] pulse);
    bit aw_done = 0, w_done = 0, b_done = 0, aw_hs, w_hs, b_hs;
    int cyc = 0;
    resp = 2'b11;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    while (!(aw_done && w_done) && cyc < 20) begin
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      step(); cyc++;
      if (aw_hs) begin S_AXI_AWVALID = 1'b0; aw_done = 1; end
      if (w_hs)  begin S_AXI_WVALID = 1'b0;  w_done = 1; end
    end
    pulse = reg_wr_pulse;
    if (!(aw_done && w_done)) begin
      n_tests++; n_fail++;
      $display("FAIL wr_addr_data_timeout: got aw=%0d w=%0d required both 1", aw_done, w_done);
    end
    cyc = 0;
    while (!b_done && cyc < 20) begin
      b_hs = S_AXI_BVALID && S_AXI_BREADY;
      if (b_hs) resp = S_AXI_BRESP;
      step(); cyc++;
      if (b_hs) b_done = 1;
    end
    S_AXI_BREADY = 1'b0;
    if (!b_done) begin
      n_tests++; n_fail++;
      $display("FAIL wr_resp_timeout: got no BVALID required BVALID within 20 cycles");
    end
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ar_done = 0, r_done = 0, ar_hs, r_hs;
    int cyc = 0;
    d = '0; resp = 2'b11;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    while (!ar_done && cyc < 20) begin
      ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
      step(); cyc++;
      if (ar_hs) begin S_AXI_ARVALID = 1'b0; ar_done = 1; end
    end
    cyc = 0;
    while (ar_done && !r_done && cyc < 20) begin
      r_hs = S_AXI_RVALID && S_AXI_RREADY;
      if (r_hs) begin d = S_AXI_RDATA; resp = S_AXI_RRESP; end
      step(); cyc++;
      if (r_hs) r_done = 1;
    end
    S_AXI_RREADY = 1'b0;
    S_AXI_ARVALID = 1'b0;
    if (!r_done) begin
      n_tests++; n_fail++;
      $display("FAIL rd_timeout: got ar=%0d r=%0d required both 1", ar_done, r_done);
    end
  endtask

  initial begin
    logic [1:0]  resp;
    logic [3:0]  pulse;
    logic [31:0] rd;

    vecs[0] = '{8'h00, 32'h0000_0001, 4'hF, 32'h0000_0001, 2'b00, 2'b00, 4'b0001};
    vecs[1] = '{8'h04, 32'h0000_0002, 4'hF, 32'h0000_0002, 2'b00, 2'b00, 4'b0010};
    vecs[2] = '{8'h08, 32'h0000_0003, 4'hF, 32'h0000_0003, 2'b00, 2'b00, 4'b0100};
    vecs[3] = '{8'h0C, 32'h0000_0004, 4'hF, 32'h0000_0004, 2'b00, 2'b00, 4'b1000};
    vecs[4] = '{8'h04, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF, 2'b00, 2'b00, 4'b0010};
    vecs[5] = '{8'h04, 32'h1234_5678, 4'h5, 32'hFF34_FF78, 2'b00, 2'b00, 4'b0010};
    vecs[6] = '{8'h10, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 2'b10, 2'b10, 4'b0000};
    vecs[7] = '{8'h07, 32'h0000_0000, 4'h0, 32'hFF34_FF78, 2'b00, 2'b00, 4'b0010};
    vecs[8] = '{8'h80, 32'h0000_0000, 4'hF, 32'h0000_0000, 2'b10, 2'b10, 4'b0000};

    // Reset state
    step(); step();
    chk("rst_regs", regs_o, 128'h0);
    chk("rst_bvalid", S_AXI_BVALID, 1'b0);
    chk("rst_rvalid", S_AXI_RVALID, 1'b0);
    chk("rst_awready", S_AXI_AWREADY, 1'b0);
    chk("rst_arready", S_AXI_ARREADY, 1'b0);
    chk("rst_pulse", reg_wr_pulse, 4'b0);
    ARESET = 1'b0;
    step();

    // Table-driven write/readback
    for (int i = 0; i < 9; i++) begin
      axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, resp, pulse);
      chk($sformatf("v%0d_bresp", i), resp, vecs[i].exp_bresp);
      chk($sformatf("v%0d_pulse", i), pulse, vecs[i].exp_pulse);
      chk($sformatf("v%0d_pulse_off", i), reg_wr_pulse, 4'b0);
      axi_read(vecs[i].addr, rd, resp);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_rresp", i), resp, vecs[i].exp_rresp);
      if (i == 3) chk("regs_after_init", regs_o, 128'h00000004_00000003_00000002_00000001);
    end
    chk("regs_after_table", regs_o, 128'h00000004_00000003_FF34FF78_00000001);

    // W ahead of AW, with write response back-pressured
    S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    chk("w_early_wready", S_AXI_WREADY, 1'b1);
    step();
    S_AXI_WVALID = 1'b0;
    chk("w_latched_wready", S_AXI_WREADY, 1'b0);
    chk("w_latched_nobvalid", S_AXI_BVALID, 1'b0);
    step(); step();
    chk("w_wait_nobvalid", S_AXI_BVALID, 1'b0);
    chk("w_wait_regs", regs_o[95:64], 32'h3);
    S_AXI_AWADDR = 8'h08; S_AXI_AWVALID = 1'b1;
    chk("aw_late_awready", S_AXI_AWREADY, 1'b1);
    step();
    S_AXI_AWVALID = 1'b0;
    chk("late_commit_bvalid", S_AXI_BVALID, 1'b1);
    chk("late_commit_pulse", reg_wr_pulse, 4'b0100);
    chk("late_commit_regs", regs_o[95:64], 32'h55);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("bhold%0d_bvalid", c), S_AXI_BVALID, 1'b1);
      chk($sformatf("bhold%0d_readies", c), {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
    end
    chk("bhold_pulse_off", reg_wr_pulse, 4'b0);
    S_AXI_BREADY = 1'b1;
    step();
    S_AXI_BREADY = 1'b0;
    chk("bdone_bvalid", S_AXI_BVALID, 1'b0);
    chk("bdone_readies", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);

    // Same-edge read and write to one register returns the old value
    axi_write(8'h08, 32'h3, 4'hF, resp, pulse);
    S_AXI_ARADDR = 8'h08; S_AXI_ARVALID = 1'b1;
    S_AXI_AWADDR = 8'h08; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'hAA; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    step();
    S_AXI_ARVALID = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    chk("coll_rvalid", S_AXI_RVALID, 1'b1);
    chk("coll_rdata", S_AXI_RDATA, 32'h3);
    chk("coll_bvalid", S_AXI_BVALID, 1'b1);
    chk("coll_arready", S_AXI_ARREADY, 1'b0);
    step();
    chk("coll_rdata_hold", S_AXI_RDATA, 32'h3);
    chk("coll_reg_new", regs_o[95:64], 32'hAA);
    S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
    step();
    S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
    chk("coll_done", {S_AXI_RVALID, S_AXI_BVALID, S_AXI_ARREADY}, 3'b001);
    axi_read(8'h08, rd, resp);
    chk("coll_reread", rd, 32'hAA);

    // Reset with both responses outstanding
    S_AXI_AWADDR = 8'h0C; S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 8'h00; S_AXI_ARVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    chk("prerst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
    #2 ARESET = 1'b1;
    #1;
    chk("midrst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    chk("midrst_regs", regs_o, 128'h0);
    chk("midrst_rdata", S_AXI_RDATA, 32'h0);
    step(); step();
    ARESET = 1'b0;
    step();
    chk("postrst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    axi_write(8'h04, 32'hCAFE_F00D, 4'hF, resp, pulse);
    chk("postrst_bresp", resp, 2'b00);
    chk("postrst_pulse", pulse, 4'b0010);
    axi_read(8'h04, rd, resp);
    chk("postrst_rdata", rd, 32'hCAFE_F00D);
    axi_read(8'h0C, rd, resp);
    chk("postrst_rdata_cleared", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
